// File: rtl/toll_booth_controller.sv
// Single-lane toll controller: accumulates coin credit, drives the go/stop lights, times out the gate.
// Optional change return of excess credit is built when TOLL_CHANGE_RETURN_EN is defined.
module toll_booth_controller #(
    parameter int TOLL_CENTS = 35,
    parameter int CREDIT_W   = 8,
    parameter int GO_TIMEOUT = 1000
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Nickel1,
    input  logic                Nickel2,
    input  logic                Dime,
    input  logic                Quarter,
    input  logic                CarPresent,
    input  logic                CarPassed,
    output logic                LEDgo,
    output logic                LEDstop,
    output logic [CREDIT_W-1:0] Credit,
    output logic                ChangeNickel,
    output logic                Timeout
);

    // Sum is wide enough for a full register plus the largest single-cycle coin total (45).
    localparam int SUM_W   = ((CREDIT_W > 6) ? CREDIT_W : 6) + 1;
    localparam int TIMER_W = $clog2(GO_TIMEOUT + 1);

    localparam logic [SUM_W-1:0]    CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [CREDIT_W-1:0] TOLL       = CREDIT_W'(TOLL_CENTS);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(GO_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_GO      = 2'd2
`ifdef TOLL_CHANGE_RETURN_EN
        , S_CHANGE = 2'd3
`endif
    } state_t;

    state_t               state_reg;
    logic                 led_go_reg;
    logic                 led_stop_reg;
    logic                 timeout_reg;
    logic [CREDIT_W-1:0]  credit_reg;
    logic [TIMER_W-1:0]   timer_reg;

    logic                 coin_accept;
    logic [3:0]           coin_vec;
    logic [5:0]           coin_term [4];
    logic [5:0]           coin_value;
    logic [SUM_W-1:0]     credit_sum;
    logic [CREDIT_W-1:0]  credit_next;
    logic                 toll_met;

    assign coin_accept = CarPresent && ((state_reg == S_IDLE) || (state_reg == S_COLLECT));
    assign coin_vec    = coin_accept ? {Quarter, Dime, Nickel2, Nickel1} : 4'b0000;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_coin
            localparam logic [5:0] WEIGHT = (gi == 3) ? 6'd25 : ((gi == 2) ? 6'd10 : 6'd5);
            assign coin_term[gi] = coin_vec[gi] ? WEIGHT : 6'd0;
        end
    endgenerate

    always_comb begin
        coin_value = '0;
        for (int i = 0; i < 4; i++) begin
            coin_value = coin_value + coin_term[i];
        end
        credit_sum  = SUM_W'(credit_reg) + SUM_W'(coin_value);
        credit_next = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0]
                                                : credit_sum[CREDIT_W-1:0];
        toll_met    = (credit_next >= TOLL);
    end

`ifdef TOLL_CHANGE_RETURN_EN
    logic change_nickel_reg;
    assign ChangeNickel = change_nickel_reg;
`else
    assign ChangeNickel = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg    <= S_IDLE;
            led_go_reg   <= 1'b0;
            led_stop_reg <= 1'b1;
            timeout_reg  <= 1'b0;
            credit_reg   <= '0;
            timer_reg    <= '0;
`ifdef TOLL_CHANGE_RETURN_EN
            change_nickel_reg <= 1'b0;
`endif
        end else begin
            timeout_reg <= 1'b0;
`ifdef TOLL_CHANGE_RETURN_EN
            change_nickel_reg <= 1'b0;
`endif
            case (state_reg)
                S_IDLE: begin
                    if (CarPresent) begin
                        state_reg  <= S_COLLECT;
                        credit_reg <= credit_next;
                    end
                end
                S_COLLECT: begin
                    if (toll_met) begin
                        state_reg    <= S_GO;
                        credit_reg   <= credit_next - TOLL;
                        led_go_reg   <= 1'b1;
                        led_stop_reg <= 1'b0;
                        timer_reg    <= '0;
                    end else begin
                        credit_reg <= credit_next;
                        if (!CarPresent) begin
                            state_reg <= S_IDLE;
                        end
                    end
                end
                S_GO: begin
                    // Timeout and the closing edge coincide; a pass in that cycle wins.
                    if (CarPassed || (timer_reg == TIMER_LAST)) begin
                        led_go_reg   <= 1'b0;
                        led_stop_reg <= 1'b1;
                        timeout_reg  <= !CarPassed;
                        timer_reg    <= '0;
`ifdef TOLL_CHANGE_RETURN_EN
                        if (credit_reg != '0) begin
                            state_reg         <= S_CHANGE;
                            change_nickel_reg <= 1'b1;
                        end else begin
                            state_reg <= S_IDLE;
                        end
`else
                        state_reg  <= S_IDLE;
                        credit_reg <= '0;
`endif
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end
`ifdef TOLL_CHANGE_RETURN_EN
                S_CHANGE: begin
                    // Debit on the edge closing each pulse cycle; floor at zero for non-multiple saturation.
                    if (change_nickel_reg) begin
                        if (credit_reg <= CREDIT_W'(5)) begin
                            credit_reg <= '0;
                            state_reg  <= S_IDLE;
                        end else begin
                            credit_reg <= credit_reg - CREDIT_W'(5);
                        end
                    end else begin
                        change_nickel_reg <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign LEDgo   = led_go_reg;
    assign LEDstop = led_stop_reg;
    assign Credit  = credit_reg;
    assign Timeout = timeout_reg;

endmodule
